bram_latency_ctrl: RTL and testbench

- Parametrised successor to the cache-line backing memory.
- Stores ROWS lines of DATA_SIZE bits each and services one request at a time through a valid/ready handshake.
- Read and write latency come from cycle counters, not simulation delays.
- Adds byte-granular write masks, a write acknowledge, and an out-of-range error response.
- Sits below the cache controller as the main-memory model. It is synthesisable.

---
 rtl/bram_latency_ctrl_if.sv | 29 ++
 rtl/bram_latency_ctrl.sv | 124 ++++++++++++
 tb/tb_bram_latency_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bram_latency_ctrl_if.sv
// Request/response bus of the latency-modelled line memory.
// The master issues line reads/writes; the slave (memory) answers with
// rvalid/wack pulses and an optional out-of-range error.
interface bram_latency_ctrl_if #(
   parameter int ADDR_SIZE   = 7,
   parameter int OFFSET_BITS = 6,
   parameter int DATA_SIZE   = 2**(OFFSET_BITS+3)
);
   logic                              req_valid;
   logic                              req_ready;
   logic                              req_write;
   logic [ADDR_SIZE+OFFSET_BITS-1:0]  req_addr;
   logic [DATA_SIZE-1:0]              wdata;
   logic [DATA_SIZE/8-1:0]            wmask;
   logic [DATA_SIZE-1:0]              rdata;
   logic                              rvalid;
   logic                              wack;
   logic                              resp_err;

   modport master (
      output req_valid, req_write, req_addr, wdata, wmask,
      input  req_ready, rdata, rvalid, wack, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, wdata, wmask,
      output req_ready, rdata, rvalid, wack, resp_err
   );
endinterface

// File: rtl/bram_latency_ctrl.sv
// Line-oriented backing memory with counter-driven read/write latency,
// byte write masks, write acknowledge and out-of-range error response.
// One request is serviced at a time: IDLE -> BUSY (latency) -> RESP -> IDLE.
module bram_latency_ctrl #(
   parameter int ADDR_SIZE     = 7,
   parameter int OFFSET_BITS   = 6,
   parameter int DATA_SIZE     = 2**(OFFSET_BITS+3),
   parameter int ROWS          = 2**ADDR_SIZE,
   parameter int READ_LATENCY  = 6,
   parameter int WRITE_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   bram_latency_ctrl_if.slave    bus
);

   localparam int BYTES   = DATA_SIZE / 8;
   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam int IDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [ADDR_SIZE:0] ROWS_LIMIT = (ADDR_SIZE+1)'(ROWS);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                 state_reg;
   logic [CNT_W-1:0]       cnt_reg;
   logic                   write_reg;
   logic [ADDR_SIZE-1:0]   row_reg;
   logic [DATA_SIZE-1:0]   wdata_reg;
   logic [BYTES-1:0]       wmask_reg;
   logic                   req_ready_reg;
   logic                   rvalid_reg;
   logic                   wack_reg;
   logic                   resp_err_reg;
   logic [DATA_SIZE-1:0]   rdata_reg;

   // Contents survive reset; only the control path is reinitialised.
   logic [DATA_SIZE-1:0]   mem [0:ROWS-1];

   logic                   row_in_range;
   logic                   access_now;
   logic [IDX_W-1:0]       row_idx;
   logic [BYTES-1:0]       byte_we;

   assign row_in_range = ({1'b0, row_reg} < ROWS_LIMIT);
   assign access_now   = (state_reg == BUSY) && (cnt_reg == '0);
   assign row_idx      = row_reg[IDX_W-1:0];

   // Per-byte write enables; a reset on the commit edge suppresses the write.
   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte_we
         assign byte_we[gi] = reset && access_now && write_reg && row_in_range && wmask_reg[gi];
      end
   endgenerate

   // Byte-masked memory write port.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BYTES; b++) begin
         if (byte_we[b]) begin
            mem[row_idx][8*b +: 8] <= wdata_reg[8*b +: 8];
         end
      end
   end

   // Control FSM with registered handshake/response outputs and registered read.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         req_ready_reg <= 1'b1;
         rvalid_reg    <= 1'b0;
         wack_reg      <= 1'b0;
         resp_err_reg  <= 1'b0;
         rdata_reg     <= '0;
      end else begin
         rvalid_reg   <= 1'b0;
         wack_reg     <= 1'b0;
         resp_err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.req_valid && req_ready_reg) begin
                  write_reg     <= bus.req_write;
                  row_reg       <= bus.req_addr[ADDR_SIZE+OFFSET_BITS-1:OFFSET_BITS];
                  wdata_reg     <= bus.wdata;
                  wmask_reg     <= bus.wmask;
                  cnt_reg       <= bus.req_write ? CNT_W'(WRITE_LATENCY - 1)
                                                 : CNT_W'(READ_LATENCY - 1);
                  req_ready_reg <= 1'b0;
                  state_reg     <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_reg == '0) begin
                  // Access happens on this edge; response is presented next cycle.
                  state_reg    <= RESP;
                  rvalid_reg   <= !write_reg;
                  wack_reg     <= write_reg;
                  resp_err_reg <= !row_in_range;
                  if (!write_reg) begin
                     rdata_reg <= row_in_range ? mem[row_idx] : '0;
                  end
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            RESP: begin
               state_reg     <= IDLE;
               req_ready_reg <= 1'b1;
            end
            default: begin
               state_reg     <= IDLE;
               req_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_reg;
   assign bus.rvalid    = rvalid_reg;
   assign bus.wack      = wack_reg;
   assign bus.resp_err  = resp_err_reg;
   assign bus.rdata     = rdata_reg;

endmodule

// File: tb/tb_bram_latency_ctrl.sv
// Scoreboard bench for bram_latency_ctrl: the stimulus process pushes the
// hand-computed response of each accepted request; a monitor pops and compares
// whenever rvalid or wack appears.
module tb_bram_latency_ctrl;

   localparam int AW = 13;
   localparam int DW = 512;
   localparam int BW = 64;
   localparam int RL = 6;
   localparam int WL = 2;

   localparam logic [DW-1:0] ALL_A5  = {64{8'hA5}};
   localparam logic [DW-1:0] ALL_FF  = {64{8'hFF}};
   localparam logic [DW-1:0] MERGED1 = {{63{8'hA5}}, 8'hFF};
   localparam logic [DW-1:0] MERGED2 = {{32{8'h3C}}, {31{8'hA5}}, 8'hFF};
   localparam logic [BW-1:0] ONES    = {BW{1'b1}};

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   bram_latency_ctrl_if #(.ADDR_SIZE(7), .OFFSET_BITS(6), .DATA_SIZE(DW)) bus();

   bram_latency_ctrl #(
      .ADDR_SIZE(7), .OFFSET_BITS(6), .DATA_SIZE(DW), .ROWS(100),
      .READ_LATENCY(RL), .WRITE_LATENCY(WL)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit            wr;
      bit            err;
      logic [DW-1:0] rd;
      int            when;
   } exp_t;

   exp_t q[$];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Issue one request, wait (bounded) for acceptance, push expected response.
   task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                        input logic [BW-1:0] m, input bit exp_err, input logic [DW-1:0] exp_rd,
                        input bit resp, output int acc);
      exp_t e;
      int   k;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.wdata     = d;
      bus.wmask     = m;
      k = 0;
      while (bus.req_ready !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      acc = -1;
      if (k >= 100) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got req_ready=0 for 100 cycles, required 1");
         bus.req_valid = 1'b0;
      end else begin
         acc    = cyc + 1;
         e.wr   = wr;
         e.err  = exp_err;
         e.rd   = exp_rd;
         e.when = acc + (wr ? WL : RL);
         if (resp) q.push_back(e);
         @(negedge clk);
         bus.req_valid = 1'b0;
         check("ready_low_busy", bus.req_ready, 1'b0);
      end
   endtask

   // Monitor: compare every response against the scoreboard head.
   initial begin
      exp_t          e;
      logic [DW-1:0] last_rd;
      last_rd = '0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            last_rd = '0;
         end else if (bus.rvalid === 1'b1 || bus.wack === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: got rvalid=%0b wack=%0b at cycle %0d, required none",
                        bus.rvalid, bus.wack, cyc);
            end else begin
               e = q.pop_front();
               check("resp_kind", {bus.rvalid, bus.wack}, e.wr ? 2'b01 : 2'b10);
               check("resp_cycle", cyc, e.when);
               check("resp_err", bus.resp_err, e.err);
               if (!e.wr) begin
                  check("rdata", bus.rdata, e.rd);
                  last_rd = e.rd;
               end else begin
                  check("rdata_hold", bus.rdata, last_rd);
               end
               $display("resp %s at cycle %0d err=%0b rdata[31:0]=%08h",
                        e.wr ? "wack  " : "rvalid", cyc, bus.resp_err, bus.rdata[31:0]);
            end
         end else if (bus.resp_err !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_err: got resp_err=%0b without response, required 0", bus.resp_err);
         end
      end
   end

   // Directed stimulus.
   initial begin
      int a_r;
      int a_w;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.wdata     = '0;
      bus.wmask     = '0;
      reset         = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1'b1);
      check("rst_rvalid",    bus.rvalid,    1'b0);
      check("rst_wack",      bus.wack,      1'b0);
      check("rst_resp_err",  bus.resp_err,  1'b0);
      check("rst_rdata",     bus.rdata,     '0);

      // Full write then read through a non-zero offset.
      issue(1'b1, 13'h0400, ALL_A5, ONES, 1'b0, '0, 1'b1, a_w);
      issue(1'b0, 13'h043F, '0, '0, 1'b0, ALL_A5, 1'b1, a_r);

      // Single-byte masked write merges with existing data.
      issue(1'b1, 13'h0400, ALL_FF, 64'h1, 1'b0, '0, 1'b1, a_w);
      issue(1'b0, 13'h0400, '0, '0, 1'b0, MERGED1, 1'b1, a_r);

      // Out-of-range row 120, then in-range read is unaffected.
      issue(1'b0, 13'h1E00, '0, '0, 1'b1, '0, 1'b1, a_r);
      issue(1'b0, 13'h0410, '0, '0, 1'b0, MERGED1, 1'b1, a_r);

      // Write presented while a read is busy is held off until after RESP.
      issue(1'b0, 13'h0400, '0, '0, 1'b0, MERGED1, 1'b1, a_r);
      issue(1'b1, 13'h0400, {64{8'h3C}}, 64'hFFFF_FFFF_0000_0000, 1'b0, '0, 1'b1, a_w);
      check("busy_accept_cycle", a_w, a_r + RL + 2);
      issue(1'b0, 13'h0400, '0, '0, 1'b0, MERGED2, 1'b1, a_r);

      // Row 5 baseline.
      issue(1'b1, 13'h0140, {64{8'h11}}, ONES, 1'b0, '0, 1'b1, a_w);
      issue(1'b0, 13'h0140, '0, '0, 1'b0, {64{8'h11}}, 1'b1, a_r);

      // Reset one cycle after accepting a write: dropped, no wack.
      issue(1'b1, 13'h0140, {64{8'h22}}, ONES, 1'b0, '0, 1'b0, a_w);
      reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      check("rst2_req_ready", bus.req_ready, 1'b1);
      check("rst2_rdata",     bus.rdata,     '0);

      // Reset landing exactly on the write commit edge: suppressed.
      issue(1'b1, 13'h0140, {64{8'h33}}, ONES, 1'b0, '0, 1'b0, a_w);
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      issue(1'b0, 13'h0140, '0, '0, 1'b0, {64{8'h11}}, 1'b1, a_r);

      // All-zero mask: wack still pulses, memory unchanged.
      issue(1'b1, 13'h0140, {64{8'h99}}, '0, 1'b0, '0, 1'b1, a_w);
      issue(1'b0, 13'h0140, '0, '0, 1'b0, {64{8'h11}}, 1'b1, a_r);

      for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
      repeat (10) @(negedge clk);
      check("queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
